// File: rtl/contador_multi_if.sv
// rtl/contador_multi_if.sv - pop/readout bus between FIFO monitor side and contador_multi
interface contador_multi_if #(
    parameter int NUM_CH = 5,
    parameter int CNT_W  = 5,
    parameter int IDX_W  = 3
);
    logic [NUM_CH-1:0] pop;
    logic              idle;
    logic              req;
    logic [IDX_W-1:0]  idx;
    logic              dump;
    logic [CNT_W-1:0]  data_out;
    logic [IDX_W-1:0]  data_idx;
    logic              valid;
    logic              busy;
    logic [NUM_CH-1:0] overflow;

    modport master (
        output pop, idle, req, idx, dump,
        input  data_out, data_idx, valid, busy, overflow
    );

    modport slave (
        input  pop, idle, req, idx, dump,
        output data_out, data_idx, valid, busy, overflow
    );
endinterface

// File: rtl/contador_multi.sv
// rtl/contador_multi.sv - per-channel FIFO pop counters with single-channel read and sequential dump
module contador_multi #(
    parameter int NUM_CH        = 5,
    parameter int CNT_W         = 5,
    parameter int IDX_W         = 3,
    parameter bit SATURATE      = 1'b1,
    parameter bit CLEAR_ON_READ = 1'b0
) (
    input  logic             clk,
    input  logic             reset_L,
    contador_multi_if.slave  bus
);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic [1:0] {ST_COUNT, ST_READ, ST_DUMP} state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic [CNT_W-1:0]  data_q, data_d;
    logic [IDX_W-1:0]  didx_q, didx_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;

    logic              rd_en;
    logic [IDX_W-1:0]  rd_ch;
    logic              rd_sel;
    logic              ovf_evt;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        didx_d  = didx_q;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        rd_en   = 1'b0;
        rd_ch   = '0;
        rd_sel  = 1'b0;
        ovf_evt = 1'b0;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_COUNT: begin
                if (bus.idle && bus.dump) begin
                    // channel 0 goes out on the accepting edge, so ptr holds the next channel
                    state_d = ST_DUMP;
                    rd_en   = 1'b1;
                    rd_ch   = '0;
                    ptr_d   = PTR_W'(1);
                    busy_d  = 1'b1;
                end else if (bus.idle && bus.req && ({1'b0, bus.idx} < PTR_W'(NUM_CH))) begin
                    state_d = ST_READ;
                    rd_en   = 1'b1;
                    rd_ch   = bus.idx;
                end
            end
            ST_READ: begin
                state_d = ST_COUNT;
            end
            ST_DUMP: begin
                if (!bus.idle || (ptr_q >= PTR_W'(NUM_CH))) begin
                    state_d = ST_COUNT;
                    ptr_d   = '0;
                end else begin
                    rd_en  = 1'b1;
                    rd_ch  = ptr_q[IDX_W-1:0];
                    ptr_d  = ptr_q + PTR_W'(1);
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_COUNT;
                ptr_d   = '0;
            end
        endcase

        if (rd_en) begin
            valid_d = 1'b1;
            didx_d  = rd_ch;
        end

        for (int i = 0; i < NUM_CH; i++) begin
            ovf_evt = bus.pop[i] && (cnt_q[i] == '1);
            rd_sel  = rd_en && (rd_ch == IDX_W'(i));
            if (rd_sel) begin
                data_d = cnt_q[i];
            end
            // a pop coinciding with a clearing read is kept, not dropped
            if (CLEAR_ON_READ && rd_sel) begin
                cnt_d[i] = CNT_W'(bus.pop[i]);
                ovf_d[i] = ovf_evt;
            end else begin
                if (bus.pop[i]) begin
                    if (ovf_evt) begin
                        cnt_d[i] = SATURATE ? cnt_q[i] : '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                ovf_d[i] = ovf_q[i] | ovf_evt;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_COUNT;
            ptr_q   <= '0;
            ovf_q   <= '0;
            data_q  <= '0;
            didx_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ovf_q   <= ovf_d;
            data_q  <= data_d;
            didx_q  <= didx_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.data_out = data_q;
    assign bus.data_idx = didx_q;
    assign bus.valid    = valid_q;
    assign bus.busy     = busy_q;
    assign bus.overflow = ovf_q;
endmodule
